// File: rtl/dmem_access_ctrl.sv
// Purpose : MEM-stage data-memory access controller; turns a load/store into a held request/ack handshake.
// Latency : request seen in IDLE -> mem_req next cycle; ack k cycles after mem_req rises -> DONE, Stall high k+1 cycles.
// Backpress: Stall freezes the upstream pipeline while an access is pending; the memory paces completion via mem_ack.
//
// Ports:
//   clock, reset           - sole clock; asynchronous active-high reset
//   MemRead, MemWrite      - load/store request from the control path
//   Addr, WriteData        - word address and store data from EX/MEM
//   ReadData               - load result to MEM/WB, held until the next completed load
//   Stall                  - pipeline freeze (combinational)
//   Err                    - sticky error: timeout or simultaneous read+write
//   mem_req/we/addr/wdata  - request to external memory, stable while mem_req is high
//   mem_rdata, mem_ack     - read data and one-cycle completion pulse from memory
module dmem_access_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [15:0] Addr,
   input  logic [15:0] WriteData,
   output logic [15:0] ReadData,
   output logic        Stall,
   output logic        Err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     nextState;
   logic [4:0] waitCnt;
   logic       accessReq;
   logic       timedOut;

   assign accessReq = MemRead | MemWrite;

   // Last permitted wait cycle elapsed with no ack; an ack on that same edge still wins.
   assign timedOut = (state == REQ) && !mem_ack && (waitCnt == 5'(TIMEOUT - 1));

   // mem_req is decoded from the state register so reset drops it without a clock edge.
   assign mem_req = (state == REQ);

   // DONE deliberately releases Stall so the pipeline advances exactly once per access.
   assign Stall = ((state == IDLE) && accessReq) || (state == REQ);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accessReq) nextState = REQ;
         REQ:     if (mem_ack || timedOut) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_we    <= 1'b0;
         mem_addr  <= 16'h0000;
         mem_wdata <= 16'h0000;
         ReadData  <= 16'h0000;
         Err       <= 1'b0;
         waitCnt   <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accessReq) begin
                  // A read+write conflict resolves to a write and is flagged.
                  mem_we    <= MemWrite;
                  mem_addr  <= Addr;
                  mem_wdata <= WriteData;
                  waitCnt   <= 5'd0;
                  if (MemRead && MemWrite) Err <= 1'b1;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  if (!mem_we) ReadData <= mem_rdata;
               end else if (timedOut) begin
                  // Abandoned load returns a recognisable poison value; a write is simply dropped.
                  Err <= 1'b1;
                  if (!mem_we) ReadData <= 16'hDEAD;
               end else begin
                  waitCnt <= waitCnt + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles in REQ awaiting mem_ack (range 2..31).
REQ-002 clock  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 MemRead  in  1  MEM-stage load request from control path.
REQ-005 MemWrite  in  1  MEM-stage store request from control path.
REQ-006 Addr  in  16  word address from ALU result.
REQ-007 WriteData  in  16  store data.
REQ-008 ReadData  out  16  load data to MEM/WB register.
REQ-009 Stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM while high.
REQ-010 Err  out  1  sticky error flag (timeout or read+write conflict).
REQ-011 mem_req  out  1  external memory request, held until ack or abort.
REQ-012 mem_we  out  1  1 = write, 0 = read; valid while mem_req high.
REQ-013 mem_addr  out  16  latched address.
REQ-014 mem_wdata  out  16  latched store data.
REQ-015 mem_rdata  in  16  memory read data, valid with mem_ack.
REQ-016 mem_ack  in  1  one-cycle completion pulse from memory.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DONE; encoding free.
REQ-018 IDLE: if MemRead or MemWrite high at edge -> REQ; latch Addr, WriteData, mem_we=MemWrite; mem_req=1; timeout counter=0.
REQ-019 MemRead and MemWrite both high in IDLE SHALL perform a write and set Err.
REQ-020 REQ: mem_ack high at edge -> DONE, mem_req=0; if mem_we=0, ReadData<=mem_rdata.
REQ-021 REQ without ack: counter increments; counter==TIMEOUT-1 without ack -> DONE, mem_req=0, Err=1, ReadData<=16'hDEAD for reads, write dropped.
REQ-022 mem_ack outside REQ SHALL be ignored (no state, ReadData or Err change).
REQ-023 DONE: unconditionally -> IDLE next edge; request already serviced, MemRead/MemWrite ignored in DONE.
REQ-024 Stall (combinational) = (IDLE and (MemRead or MemWrite)) or REQ; Stall=0 in DONE so pipeline advances exactly once per access.
REQ-025 Back-to-back memory instructions: second seen in IDLE after DONE; no request lost or duplicated.
REQ-026 mem_addr, mem_wdata, mem_we SHALL remain stable while mem_req high regardless of input changes.
REQ-027 Latency: ack k cycles after mem_req rises (k>=1) gives Stall high k+1 cycles; ReadData valid in DONE cycle and held until next completed read.
REQ-028 Writes SHALL not change ReadData.
REQ-029 Err SHALL stay set until reset.

Reset
REQ-030 reset high SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData=0, Err=0, counter=0.
REQ-031 Reset during REQ SHALL abort the access with no ReadData update; mem_req drops without waiting for clock.
REQ-032 After reset release, first edge with request SHALL behave per REQ-018.

Verification
REQ-033 Load: MemRead=1, Addr=16'h0010, ack 1 cycle after req with mem_rdata=16'h1234 -> Stall high 2 cycles, ReadData=16'h1234 in DONE, Err=0.
REQ-034 Store: MemWrite=1, Addr=16'h0020, WriteData=16'hBEEF, ack after 3 cycles -> mem_we=1, mem_addr/mem_wdata stable 3 cycles, Stall high 4 cycles, ReadData unchanged.
REQ-035 Timeout: TIMEOUT=16, MemRead=1, no ack -> mem_req high 16 cycles, then ReadData=16'hDEAD, Err=1, FSM returns to IDLE.
REQ-036 Conflict: MemRead=MemWrite=1 -> write issued (mem_we=1), Err=1 after completion.
REQ-037 Back-to-back: load then store in consecutive instructions, ack 1 cycle each -> exactly two mem_req pulses, one DONE cycle between, correct data each.
REQ-038 Reset mid-access: assert reset 2 cycles into REQ -> mem_req=0 asynchronously, ReadData=0, later stray mem_ack ignored.
